// File: rtl/sram_like_resp_mem.sv
// sram_like_resp_mem: responder end of the SRAM-like data port.
// Word-organised memory with byte-lane writes, in-order pipelined completion,
// programmable address-handshake hold (ADDR_LAT) and completion latency (DATA_LAT).
// Optional feature: define SRAM_RESP_RAND_STALL_EN to add LFSR-driven addr_ok stalls.
module sram_like_resp_mem #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned ADDR_LAT = 0,
   parameter int unsigned DATA_LAT = 2,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int unsigned WORDS  = 1 << ADDR_W;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned HOLD_W = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
   localparam int unsigned LAT_W  = 4;

   logic [31:0]       mem [WORDS];
   logic [ADDR_W-1:0] widx;
   logic [3:0]        lane_en;
   logic              push;
   logic              pop;
   logic              lat_met;
   logic              stall;

   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              ent_rd       [DEPTH];
   logic              ent_rd_nxt   [DEPTH];
   logic [31:0]       ent_data     [DEPTH];
   logic [31:0]       ent_data_nxt [DEPTH];
   logic [LAT_W-1:0]  ent_cnt      [DEPTH];
   logic [LAT_W-1:0]  ent_cnt_nxt  [DEPTH];
   logic              data_ok_nxt;
   logic [31:0]       rdata_nxt;

   // Upper address bits alias onto the same words.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   assign widx = addr[ADDR_W+1:2];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Byte-lane enables; misaligned or reserved sizes write nothing.
   always_comb begin
      lane_en = 4'b0000;
      case (size)
         2'b00:   lane_en[addr[1:0]] = 1'b1;
         2'b01:   if (!addr[0]) lane_en = addr[1] ? 4'b1100 : 4'b0011;
         2'b10:   if (addr[1:0] == 2'b00) lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

`ifdef SRAM_RESP_RAND_STALL_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR (taps 16,14,13,11) gating addr_ok pseudo-randomly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // hold_cnt >= ADDR_LAT, written so the ADDR_LAT=0 case is not a constant compare.
   assign lat_met = (32'(hold_cnt) + 32'd1) > ADDR_LAT;
   assign addr_ok = req && !rst && lat_met && (count < CNT_W'(DEPTH)) && !stall;
   assign push    = addr_ok;
   assign pop     = data_ok;

   // Next-state: hold counter, queue entries/pointers and the registered completion.
   always_comb begin
      hold_cnt_nxt = hold_cnt;
      ent_rd_nxt   = ent_rd;
      ent_data_nxt = ent_data;
      ent_cnt_nxt  = ent_cnt;
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;

      if (!req || push)  hold_cnt_nxt = '0;
      else if (!lat_met) hold_cnt_nxt = hold_cnt + HOLD_W'(1);

      for (int i = 0; i < DEPTH; i++)
         if (ent_cnt[i] != '0) ent_cnt_nxt[i] = ent_cnt[i] - LAT_W'(1);

      // Countdown reaches zero on the edge that starts the data_ok cycle.
      if (push) begin
         ent_rd_nxt[wr_ptr]   = !wr;
         ent_data_nxt[wr_ptr] = wr ? 32'd0 : mem[widx];
         ent_cnt_nxt[wr_ptr]  = LAT_W'(DATA_LAT - 1);
         wr_ptr_nxt           = ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr_nxt = ptr_inc(rd_ptr);

      count_nxt   = count + CNT_W'(push) - CNT_W'(pop);
      data_ok_nxt = (count_nxt != '0) && (ent_cnt_nxt[rd_ptr_nxt] == '0);
      rdata_nxt   = (data_ok_nxt && ent_rd_nxt[rd_ptr_nxt]) ? ent_data_nxt[rd_ptr_nxt] : 32'd0;
   end

   // Control and queue state; reset discards all outstanding entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_ok  <= 1'b0;
         rdata    <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i]   <= 1'b0;
            ent_data[i] <= 32'd0;
            ent_cnt[i]  <= '0;
         end
      end else begin
         hold_cnt <= hold_cnt_nxt;
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         data_ok  <= data_ok_nxt;
         rdata    <= rdata_nxt;
         ent_rd   <= ent_rd_nxt;
         ent_data <= ent_data_nxt;
         ent_cnt  <= ent_cnt_nxt;
      end
   end

   // Memory array: writes commit on the acceptance edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (push && wr) begin
         for (int k = 0; k < 4; k++)
            if (lane_en[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
   end

endmodule
